pipeline_hazard_ctrl: RTL

//  Pipeline hazard controller for the 5-stage 19-bit core. Sits beside the decode controller.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_if.sv | 18 +
 rtl/pipeline_hazard_ctrl_fwd_sel.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state, forwarding and pc_src encodings for the hazard/decode controllers
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} hz_state_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_RET = 2'd3;
  localparam int RA_MAX = 8;
  function automatic logic hz_match(logic [RA_MAX-1:0] x, logic [RA_MAX-1:0] src, logic r0_zero);
    return (x == src) && (!r0_zero || x != '0);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: stage register addresses/controls in, stall/flush/forward controls out
interface pipeline_hazard_ctrl_if #(parameter int RA_W = 3, parameter int CNT_W = 16);
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, id_halt, ex_mem_read, mem_wr, wb_wr, ex_redirect;
  logic pc_write, ifid_write, ifid_flush, idex_flush, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    output id_use1, id_use2, id_halt, ex_mem_read, mem_wr, wb_wr, ex_redirect,
    input pc_write, ifid_write, ifid_flush, idex_flush, halted, fwd_a, fwd_b, stall_cnt
  );
  modport slave (
    input id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    input id_use1, id_use2, id_halt, ex_mem_read, mem_wr, wb_wr, ex_redirect,
    output pc_write, ifid_write, ifid_flush, idex_flush, halted, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// pipeline_hazard_ctrl_fwd_sel: EX operand bypass select, MEM result preferred over WB
module pipeline_hazard_ctrl_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [RA_W-1:0] i_src,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic            i_mem_wr,
  input  logic            i_wb_wr,
  output logic [1:0]      o_sel
);
  logic w_mem, w_wb;
  assign w_mem = i_mem_wr && hz_match(RA_MAX'(i_mem_rd), RA_MAX'(i_src), R0_ZERO);
  assign w_wb = i_wb_wr && hz_match(RA_MAX'(i_wb_rd), RA_MAX'(i_src), R0_ZERO);
  assign o_sel = w_mem ? FWD_MEM : w_wb ? FWD_WB : FWD_REG;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, redirect flush, halt drain sequencing and forwarding selects
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 3,
  parameter bit R0_ZERO = 1'b1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  hz_state_t r_state, w_next;
  logic [DW-1:0] r_drain, w_drain_next;
  logic [CNT_W-1:0] r_stall;
  logic w_ld_use, w_stall;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush, w_halted;
  assign w_ld_use = hz.ex_mem_read &&
    ((hz.id_use1 && hz_match(RA_MAX'(hz.ex_rd), RA_MAX'(hz.id_rs1), R0_ZERO)) ||
     (hz.id_use2 && hz_match(RA_MAX'(hz.ex_rd), RA_MAX'(hz.id_rs2), R0_ZERO)));
  always_comb begin
    w_next = r_state;
    w_drain_next = r_drain;
    w_pc_write = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.ex_redirect) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (w_ld_use || hz.id_halt) begin
          w_pc_write = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          w_next = w_ld_use ? RUN : DRAIN;
          w_drain_next = w_ld_use ? r_drain : DW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (hz.ex_redirect) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_next = RUN;
          w_drain_next = '0;
        end else begin
          w_pc_write = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          w_next = (r_drain == '0) ? HALTED : DRAIN;
          w_drain_next = (r_drain == '0) ? r_drain : r_drain - DW'(1);
        end
      end
      HALTED: begin
        w_pc_write = 1'b0;
        w_ifid_write = 1'b0;
        w_idex_flush = 1'b1;
        w_halted = 1'b1;
      end
      default: w_next = RUN;
    endcase
  end
  // halted cycles are idle, not stalls
  assign w_stall = (!w_pc_write || w_ifid_flush) && (r_state != HALTED);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_drain <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_next;
      if (w_stall && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
    end
  end
  assign hz.pc_write = w_pc_write;
  assign hz.ifid_write = w_ifid_write;
  assign hz.ifid_flush = w_ifid_flush;
  assign hz.idex_flush = w_idex_flush;
  assign hz.halted = w_halted;
  assign hz.stall_cnt = r_stall;
  pipeline_hazard_ctrl_fwd_sel #(.RA_W(RA_W), .R0_ZERO(R0_ZERO)) u_fwd_a (
    .i_src(hz.ex_rs1), .i_mem_rd(hz.mem_rd), .i_wb_rd(hz.wb_rd),
    .i_mem_wr(hz.mem_wr), .i_wb_wr(hz.wb_wr), .o_sel(hz.fwd_a)
  );
  pipeline_hazard_ctrl_fwd_sel #(.RA_W(RA_W), .R0_ZERO(R0_ZERO)) u_fwd_b (
    .i_src(hz.ex_rs2), .i_mem_rd(hz.mem_rd), .i_wb_rd(hz.wb_rd),
    .i_mem_wr(hz.mem_wr), .i_wb_wr(hz.wb_wr), .o_sel(hz.fwd_b)
  );
endmodule
